// File: rtl/rv4028_bus_pkg.sv
// Shared types and constants for the rv4028 halfword memory responder.
// Byte masks are active-low to match the wrm_n bus pins.
package rv4028_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  typedef logic [15:0] halfword_t;

  localparam int WAIT_CNT_W = 4;

  localparam logic [1:0] WRM_BOTH = 2'b00;
  localparam logic [1:0] WRM_HI   = 2'b01;
  localparam logic [1:0] WRM_LO   = 2'b10;
  localparam logic [1:0] WRM_NONE = 2'b11;

  // Overlay the bytes selected by an active-low mask onto an old halfword.
  function automatic halfword_t merge_hw(halfword_t old_hw, halfword_t new_hw, logic [1:0] wrm_n);
    halfword_t res;
    res = old_hw;
    if (!wrm_n[0]) res[7:0]  = new_hw[7:0];
    if (!wrm_n[1]) res[15:8] = new_hw[15:8];
    return res;
  endfunction

endpackage

// File: rtl/rv4028_resp_mem.sv
// 2^AW x 16 storage with per-byte write enables and an asynchronous read port.
// Contents are never reset.
module rv4028_resp_mem
  import rv4028_bus_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [1:0]    i_we,
  input  logic [AW-1:0] i_waddr,
  input  halfword_t     i_wdata,
  input  logic [AW-1:0] i_raddr,
  output halfword_t     o_rdata
);

  halfword_t r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we[0]) r_mem[i_waddr][7:0]  <= i_wdata[7:0];
    if (i_we[1]) r_mem[i_waddr][15:8] <= i_wdata[15:8];
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rv4028_mem_responder.sv
// Bus-side halfword memory responder: zero-wait writes, READ_WAIT-cycle reads with wait_n.
// Optional one-entry read-ahead buffer for the odd halfword is enabled by RV4028_RESP_RDBUF_EN.
module rv4028_mem_responder
  import rv4028_bus_pkg::*;
#(
  parameter int          AW        = 10,
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter int          READ_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [1:0]  wrm_n,
  input  logic        mreq_n,
  output logic        wait_n,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_oe
);

  logic                  w_sel;
  logic [AW-1:0]         w_row;
  logic                  w_wr;
  logic                  w_rd_req;
  logic [1:0]            w_we;
  logic [AW-1:0]         w_raddr;
  halfword_t             w_rdata;
  halfword_t             w_fwd;
  logic                  w_buf_hit;
  halfword_t             w_buf_dat;
  logic                  w_unused;

  rd_state_e             r_state;
  logic [AW-1:0]         r_row;
  logic [WAIT_CNT_W-1:0] r_cnt;
  halfword_t             r_dout;
  logic                  r_oe;

  assign w_sel    = !mreq_n && (addr[31:AW+1] == BASE[31:AW+1]);
  assign w_row    = addr[AW:1];
  assign w_wr     = rst_n && w_sel && !wr_n;
  assign w_rd_req = w_sel && !rd_n && wr_n;
  assign w_we     = w_wr ? ~wrm_n : 2'b00;
  assign w_unused = addr[0];

  // One read port is shared: request row in IDLE, captured row in WAIT, odd neighbour in DATA.
  always_comb begin
    w_raddr = r_row;
    case (r_state)
      ST_IDLE: w_raddr = w_row;
      ST_DATA: w_raddr = {r_row[AW-1:1], 1'b1};
      default: w_raddr = r_row;
    endcase
  end

  // A write landing on the row being sampled in the same cycle is forwarded.
  assign w_fwd = (w_wr && (w_row == w_raddr)) ? merge_hw(w_rdata, data_in, wrm_n) : w_rdata;

  rv4028_resp_mem #(.AW(AW)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_row),
    .i_wdata (data_in),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

`ifdef RV4028_RESP_RDBUF_EN
  logic          r_buf_vld;
  logic [AW-1:0] r_buf_row;
  halfword_t     r_buf_dat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf_vld <= 1'b0;
    end else if (r_state == ST_DATA && !r_row[0]) begin
      r_buf_vld <= 1'b1;
      r_buf_row <= w_raddr;
      r_buf_dat <= w_fwd;
    end else if (w_wr && (w_row == r_buf_row)) begin
      r_buf_vld <= 1'b0;
    end
  end

  assign w_buf_hit = r_buf_vld && (r_buf_row == w_row);
  assign w_buf_dat = r_buf_dat;
`else
  assign w_buf_hit = 1'b0;
  assign w_buf_dat = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_oe    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rd_req) begin
            r_row <= w_row;
            r_cnt <= WAIT_CNT_W'(READ_WAIT);
            if (w_buf_hit) begin
              r_state <= ST_DATA;
              r_oe    <= 1'b1;
              r_dout  <= w_buf_dat;
            end else if (READ_WAIT == 0) begin
              r_state <= ST_DATA;
              r_oe    <= 1'b1;
              r_dout  <= w_fwd;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Read released, deselected, or overridden by a write: drop it silently.
          if (!w_rd_req) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt <= WAIT_CNT_W'(1)) begin
            r_state <= ST_DATA;
            r_oe    <= 1'b1;
            r_dout  <= w_fwd;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - WAIT_CNT_W'(1);
          end
        end
        ST_DATA: begin
          r_state <= ST_IDLE;
          r_oe    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  assign wait_n   = !(rst_n && w_sel && !rd_n && (r_state != ST_DATA));
  assign data_oe  = r_oe;
  assign data_out = r_dout;

endmodule

// File: tb/tb_rv4028_mem_responder.sv
// Directed bench for rv4028_mem_responder: a per-cycle vector table on a READ_WAIT=2 instance
// plus hand sequences for reset, mid-read reset and abort on a READ_WAIT=3 instance.
module tb_rv4028_mem_responder;
  import rv4028_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        rd_n, wr_n, mreq_n;
  logic [1:0]  wrm_n;
  logic [15:0] data_in;
  logic        wait_a, oe_a, wait_b, oe_b;
  logic [15:0] dout_a, dout_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv4028_mem_responder #(.AW(10), .BASE(32'h0), .READ_WAIT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd_n(rd_n), .wr_n(wr_n), .wrm_n(wrm_n),
    .mreq_n(mreq_n), .wait_n(wait_a), .data_in(data_in), .data_out(dout_a), .data_oe(oe_a)
  );

  rv4028_mem_responder #(.AW(10), .BASE(32'h0), .READ_WAIT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd_n(rd_n), .wr_n(wr_n), .wrm_n(wrm_n),
    .mreq_n(mreq_n), .wait_n(wait_b), .data_in(data_in), .data_out(dout_b), .data_oe(oe_b)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic        r, w;
    logic [1:0]  m;
    logic        q;
    logic [15:0] d;
    logic        e_wait, e_oe, chk_d;
    logic [15:0] e_dout;
  } vec_t;

  vec_t vq[$];

  function automatic void add(string nm, logic [31:0] a, logic r, logic w, logic [1:0] m, logic q,
                              logic [15:0] d, logic ew, logic eo, logic cd, logic [15:0] ed);
    vec_t v;
    v.name = nm; v.a = a; v.r = r; v.w = w; v.m = m; v.q = q; v.d = d;
    v.e_wait = ew; v.e_oe = eo; v.chk_d = cd; v.e_dout = ed;
    vq.push_back(v);
  endfunction

  function automatic void v_rd(string nm, logic [31:0] a, logic ew, logic eo, logic [15:0] ed);
    add(nm, a, 1'b0, 1'b1, WRM_NONE, 1'b0, 16'h0, ew, eo, eo, ed);
  endfunction

  function automatic void v_wr(string nm, logic [31:0] a, logic [15:0] d, logic [1:0] m);
    add(nm, a, 1'b1, 1'b0, m, 1'b0, d, 1'b1, 1'b0, 1'b0, 16'h0);
  endfunction

  function automatic void v_idle(string nm);
    add(nm, 32'h0, 1'b1, 1'b1, WRM_NONE, 1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
  endfunction

  // Full READ_WAIT=2 read: wait_n low for three cycles, DATA on the fourth.
  function automatic void v_read4(string nm, logic [31:0] a, logic [15:0] ed);
    v_rd({nm, "_c0"}, a, 1'b0, 1'b0, 16'h0);
    v_rd({nm, "_c1"}, a, 1'b0, 1'b0, 16'h0);
    v_rd({nm, "_c2"}, a, 1'b0, 1'b0, 16'h0);
    v_rd({nm, "_c3"}, a, 1'b1, 1'b1, ed);
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(logic rst, logic [31:0] a, logic r, logic w, logic [1:0] m, logic q, logic [15:0] d);
    @(negedge clk);
    rst_n = rst; addr = a; rd_n = r; wr_n = w; wrm_n = m; mreq_n = q; data_in = d;
    #1;
  endtask

  task automatic set_idle();
    set_in(1'b1, 32'h0, 1'b1, 1'b1, WRM_NONE, 1'b1, 16'h0);
  endtask

  task automatic set_rd(logic [31:0] a);
    set_in(1'b1, a, 1'b0, 1'b1, WRM_NONE, 1'b0, 16'h0);
  endtask

  initial begin
    rst_n = 1'b0; addr = 32'h0; rd_n = 1'b1; wr_n = 1'b1; wrm_n = WRM_NONE; mreq_n = 1'b1; data_in = 16'h0;

    // Reset: wait_n held high even with a selected read pending.
    set_in(1'b0, 32'h10, 1'b0, 1'b1, WRM_NONE, 1'b0, 16'h0);
    chk("rst_wait_rd", {15'h0, wait_a}, 16'h1);
    set_in(1'b0, 32'h0, 1'b1, 1'b1, WRM_NONE, 1'b1, 16'h0);
    set_idle();
    chk("rst_wait_a", {15'h0, wait_a}, 16'h1);
    chk("rst_oe_a",   {15'h0, oe_a},   16'h0);
    chk("rst_dout_a", dout_a,          16'h0);
    chk("rst_oe_b",   {15'h0, oe_b},   16'h0);
    chk("rst_dout_b", dout_b,          16'h0);

    // Byte-masked writes then a read of the merged halfword.
    v_wr("w10_full", 32'h10, 16'h1234, WRM_BOTH);
    v_wr("w10_hi",   32'h10, 16'hAB00, WRM_HI);
    v_read4("r10", 32'h10, 16'hAB34);
    v_idle("idle0");

    // 32-bit read as two back-to-back halfwords.
    v_wr("w20", 32'h20, 16'h5678, WRM_BOTH);
    v_wr("w22", 32'h22, 16'h9ABC, WRM_BOTH);
    v_read4("r20", 32'h20, 16'h5678);
`ifdef RV4028_RESP_RDBUF_EN
    v_rd("r22_c4", 32'h22, 1'b0, 1'b0, 16'h0);
    v_rd("r22_c5", 32'h22, 1'b1, 1'b1, 16'h9ABC);
`else
    v_rd("r22_c4", 32'h22, 1'b0, 1'b0, 16'h0);
    v_rd("r22_c5", 32'h22, 1'b0, 1'b0, 16'h0);
    v_rd("r22_c6", 32'h22, 1'b0, 1'b0, 16'h0);
    v_rd("r22_c7", 32'h22, 1'b1, 1'b1, 16'h9ABC);
`endif
    v_idle("idle1");

    // Write to the row the read-ahead buffer may hold, then a full-latency read.
    v_wr("w22_ff", 32'h22, 16'hFFFF, WRM_BOTH);
    v_read4("r22_new", 32'h22, 16'hFFFF);
    v_idle("idle2");

    // Out-of-range and unqualified accesses.
    for (int i = 0; i < 3; i++) v_rd($sformatf("oor_8000_%0d", i), 32'h8000_0000, 1'b1, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) v_rd($sformatf("oor_0800_%0d", i), 32'h0000_0800, 1'b1, 1'b0, 16'h0);
    v_wr("w810_oor", 32'h0000_0810, 16'h0000, WRM_BOTH);
    add("r10_nomreq0", 32'h10, 1'b0, 1'b1, WRM_NONE, 1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    add("r10_nomreq1", 32'h10, 1'b0, 1'b1, WRM_NONE, 1'b1, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0);
    v_read4("r10_noalias", 32'h10, 16'hAB34);
    v_idle("idle3");

    // Simultaneous read and write: write wins, no read cycle follows.
    add("rw30", 32'h30, 1'b0, 1'b0, WRM_BOTH, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) v_idle($sformatf("rw30_idle%0d", i));
    v_read4("r30", 32'h30, 16'h1111);
    v_idle("idle4");

    // Write during WAIT aborts the pending read.
    v_rd("r40_c0", 32'h40, 1'b0, 1'b0, 16'h0);
    v_rd("r40_c1", 32'h40, 1'b0, 1'b0, 16'h0);
    add("rw40", 32'h40, 1'b0, 1'b0, WRM_BOTH, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) v_idle($sformatf("rw40_idle%0d", i));
    v_read4("r40", 32'h40, 16'h2222);
    v_idle("idle5");

    // Lower-byte-only write.
    v_wr("w10_lo", 32'h10, 16'h00CD, WRM_LO);
    v_read4("r10_lo", 32'h10, 16'hABCD);
    for (int i = 0; i < 4; i++) v_idle($sformatf("idle6_%0d", i));

    foreach (vq[i]) begin
      set_in(1'b1, vq[i].a, vq[i].r, vq[i].w, vq[i].m, vq[i].q, vq[i].d);
      chk({vq[i].name, "_wait"}, {15'h0, wait_a}, {15'h0, vq[i].e_wait});
      chk({vq[i].name, "_oe"},   {15'h0, oe_a},   {15'h0, vq[i].e_oe});
      if (vq[i].chk_d) chk({vq[i].name, "_dout"}, dout_a, vq[i].e_dout);
    end

    // READ_WAIT=3 instance: rd_n released in cycle 1 aborts the read.
    set_rd(32'h10);
    chk("abort_c0_wait", {15'h0, wait_b}, 16'h0);
    set_idle();
    chk("abort_c1_state", {14'h0, dut_b.r_state}, {14'h0, ST_WAIT});
    chk("abort_c1_oe", {15'h0, oe_b}, 16'h0);
    set_idle();
    chk("abort_c2_state", {14'h0, dut_b.r_state}, {14'h0, ST_IDLE});
    for (int i = 3; i < 8; i++) begin
      set_idle();
      chk($sformatf("abort_c%0d_oe", i), {15'h0, oe_b}, 16'h0);
    end

    // READ_WAIT=3 latency: DATA on cycle 4.
    for (int i = 0; i < 4; i++) begin
      set_rd(32'h10);
      chk($sformatf("b_lat_c%0d_wait", i), {15'h0, wait_b}, 16'h0);
      chk($sformatf("b_lat_c%0d_oe", i),   {15'h0, oe_b},   16'h0);
    end
    set_rd(32'h10);
    chk("b_lat_c4_oe",   {15'h0, oe_b}, 16'h1);
    chk("b_lat_c4_dout", dout_b,        16'hABCD);
    for (int i = 0; i < 5; i++) set_idle();

    // Reset in mid-read with a write pending: no write, read abandoned, data_out cleared.
    set_rd(32'h10);
    set_rd(32'h10);
    set_in(1'b0, 32'h10, 1'b1, 1'b0, WRM_BOTH, 1'b0, 16'h0000);
    chk("mrst_wait", {15'h0, wait_a}, 16'h1);
    set_idle();
    chk("mrst_oe",   {15'h0, oe_a}, 16'h0);
    chk("mrst_dout", dout_a,        16'h0);
    for (int i = 0; i < 3; i++) begin
      set_idle();
      chk($sformatf("mrst_idle%0d_oe", i), {15'h0, oe_a}, 16'h0);
    end
    for (int i = 0; i < 3; i++) begin
      set_rd(32'h10);
      chk($sformatf("mrst_r_c%0d_wait", i), {15'h0, wait_a}, 16'h0);
    end
    set_rd(32'h10);
    chk("mrst_r_c3_oe",   {15'h0, oe_a}, 16'h1);
    chk("mrst_r_c3_dout", dout_a,        16'hABCD);
    set_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
